// File: rtl/soc_bus_fabric_pkg.sv
// Shared types and defaults for the CPU-to-slave bus fabric.
// Holds the FSM and error encodings and the default tag decode constants.
package soc_bus_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ERR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_UNMAP = 2'b01,
    ERR_TOUT  = 2'b10,
    ERR_PROTO = 2'b11
  } err_code_t;

  localparam logic [15:0] DEF_PERIPH_BASE = 16'h0040;
  localparam int          DEF_TAG_HI      = 31;
  localparam int          DEF_TAG_LO      = 16;

endpackage

// File: rtl/bus_addr_decode.sv
// Tag-field decoder: one-hot slave select, slave 0 as the default target.
// Tags in the reserved peripheral window with no slave behind them are flagged unmapped.
module bus_addr_decode
  import soc_bus_fabric_pkg::*;
#(
  parameter int          N_SLAVES    = 7,
  parameter int          TAG_W       = 16,
  parameter logic [15:0] PERIPH_BASE = DEF_PERIPH_BASE,
  parameter int          PERIPH_SPAN = 16
) (
  input  logic [TAG_W-1:0]    tag,
  output logic [N_SLAVES-1:0] sel,
  output logic                unmapped
);

  logic [TAG_W-1:0] offset;
  logic             in_window;

  assign offset    = tag - TAG_W'(PERIPH_BASE);
  assign in_window = (tag >= TAG_W'(PERIPH_BASE)) && (offset < TAG_W'(PERIPH_SPAN));
  assign sel[0]    = ~in_window;
  assign unmapped  = in_window && (offset >= TAG_W'(N_SLAVES - 1));

  genvar gi;
  generate
    for (gi = 1; gi < N_SLAVES; gi++) begin : g_sel
      assign sel[gi] = in_window && (offset == TAG_W'(gi - 1));
    end
  endgenerate

endmodule

// File: rtl/soc_bus_fabric.sv
// Address decode, read-data mux and wait-state controller between the CPU port and N slaves,
// with bus timeout, unmapped-window detection and a sticky first-error log.
module soc_bus_fabric
  import soc_bus_fabric_pkg::*;
#(
  parameter int                N_SLAVES    = 7,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                TAG_HI      = DEF_TAG_HI,
  parameter int                TAG_LO      = DEF_TAG_LO,
  parameter logic [15:0]       PERIPH_BASE = DEF_PERIPH_BASE,
  parameter int                PERIPH_SPAN = 16,
  parameter int                TIMEOUT     = 255,
  parameter logic [DATA_W-1:0] ERR_DATA    = 32'h66666666
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_wmask,
  input  logic                         m_rstrb,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_rbusy,
  output logic                         m_wbusy,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [N_SLAVES-1:0]          s_cs,
  output logic [N_SLAVES-1:0]          s_rstrb,
  output logic [N_SLAVES*DATA_W/8-1:0] s_wmask,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]          s_busy,
  input  logic                         err_clr,
  output logic                         bus_err,
  output logic [ADDR_W-1:0]            err_addr,
  output logic [1:0]                   err_code
);

  localparam int          MASK_W    = DATA_W / 8;
  localparam int          TAG_W     = TAG_HI - TAG_LO + 1;
  localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT - 1);

  state_t              state_reg, state_next;
  logic [N_SLAVES-1:0] sel, sel_reg;
  logic                unmapped, unmapped_reg, rd_op_reg;
  logic [ADDR_W-1:0]   addr_reg, err_addr_reg, new_addr;
  logic [15:0]         cnt_reg;
  logic [DATA_W-1:0]   rdata_reg, rd_mux;
  logic                bus_err_reg, busy_sel, fwd_en, req_rd, req_wr, new_err;
  logic [1:0]          err_code_reg;
  err_code_t           new_code;

  bus_addr_decode #(
    .N_SLAVES    (N_SLAVES),
    .TAG_W       (TAG_W),
    .PERIPH_BASE (PERIPH_BASE),
    .PERIPH_SPAN (PERIPH_SPAN)
  ) u_decode (
    .tag      (m_addr[TAG_HI:TAG_LO]),
    .sel      (sel),
    .unmapped (unmapped)
  );

  assign req_rd  = m_rstrb;
  assign req_wr  = |m_wmask;
  // Strobes only leave the fabric while idle and never while reset is held.
  assign fwd_en  = (state_reg == IDLE) && !reset;
  assign s_addr  = m_addr;
  assign s_wdata = m_wdata;
  assign s_cs    = sel;
  assign s_rstrb = (fwd_en && req_rd) ? sel : '0;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_wmask
      assign s_wmask[gi*MASK_W +: MASK_W] = (fwd_en && !req_rd && sel[gi]) ? m_wmask : '0;
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_reg[i]) rd_mux = rd_mux | s_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign busy_sel = |(s_busy & sel_reg);
  assign m_rbusy  = (state_reg == RD) && !unmapped_reg && busy_sel;
  assign m_wbusy  = (state_reg == WR) && busy_sel;
  assign bus_err  = bus_err_reg;
  assign err_addr = err_addr_reg;
  assign err_code = err_code_reg;

  always_comb begin
    case (state_reg)
      RD:      m_rdata = unmapped_reg ? ERR_DATA : rd_mux;
      ERR:     m_rdata = rd_op_reg ? ERR_DATA : rdata_reg;
      default: m_rdata = rdata_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    new_err    = 1'b0;
    new_code   = ERR_NONE;
    new_addr   = m_addr;
    case (state_reg)
      IDLE: begin
        if (req_rd) begin
          state_next = RD;
          if (req_wr) begin
            new_err  = 1'b1;
            new_code = ERR_PROTO;
          end
        end else if (req_wr) begin
          if (unmapped) begin
            new_err  = 1'b1;
            new_code = ERR_UNMAP;
          end else if (|(s_busy & sel)) begin
            state_next = WR;
          end
        end
      end
      RD, WR: begin
        if (state_reg == RD && unmapped_reg) begin
          state_next = IDLE;
          new_err    = 1'b1;
          new_code   = ERR_UNMAP;
          new_addr   = addr_reg;
        end else if (!busy_sel) begin
          state_next = IDLE;
        end else if (cnt_reg == TOUT_LAST) begin
          state_next = ERR;
        end
        if (!new_err && (req_rd || req_wr)) begin
          new_err  = 1'b1;
          new_code = ERR_PROTO;
        end
      end
      default: begin
        state_next = IDLE;
        new_err    = 1'b1;
        new_code   = ERR_TOUT;
        new_addr   = addr_reg;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      sel_reg      <= '0;
      unmapped_reg <= 1'b0;
      rd_op_reg    <= 1'b0;
      addr_reg     <= '0;
      cnt_reg      <= '0;
      rdata_reg    <= '0;
      bus_err_reg  <= 1'b0;
      err_addr_reg <= '0;
      err_code_reg <= ERR_NONE;
    end else begin
      state_reg <= state_next;
      rdata_reg <= m_rdata;
      if (state_reg == IDLE) begin
        cnt_reg <= '0;
        if (state_next != IDLE) begin
          sel_reg      <= sel;
          unmapped_reg <= unmapped;
          addr_reg     <= m_addr;
          rd_op_reg    <= req_rd;
        end
      end else if (busy_sel) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
      // A clear coinciding with a new error still captures that error.
      if (new_err && (err_clr || !bus_err_reg)) begin
        bus_err_reg  <= 1'b1;
        err_addr_reg <= new_addr;
        err_code_reg <= new_code;
      end else if (err_clr) begin
        bus_err_reg  <= 1'b0;
        err_addr_reg <= '0;
        err_code_reg <= ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric: reads, wait states, timeout, unmapped/protocol errors and reset.
module tb_soc_bus_fabric;

  localparam int N  = 7;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [MW-1:0]   m_wmask;
  logic            m_rstrb;
  logic [DW-1:0]   m_rdata;
  logic            m_rbusy, m_wbusy;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [N-1:0]    s_cs, s_rstrb;
  logic [N*MW-1:0] s_wmask;
  logic [N*DW-1:0] s_rdata;
  logic [N-1:0]    s_busy;
  logic            err_clr;
  logic            bus_err;
  logic [AW-1:0]   err_addr;
  logic [1:0]      err_code;

  int errors = 0;
  int checks = 0;

  soc_bus_fabric #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rstrb(m_rstrb), .m_rdata(m_rdata), .m_rbusy(m_rbusy), .m_wbusy(m_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_cs(s_cs), .s_rstrb(s_rstrb), .s_wmask(s_wmask),
    .s_rdata(s_rdata), .s_busy(s_busy), .err_clr(err_clr), .bus_err(bus_err),
    .err_addr(err_addr), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; m_addr = '0; m_wdata = '0; m_wmask = '0; m_rstrb = 1'b0;
    s_rdata = '0; s_busy = '0; err_clr = 1'b0;
    #2;
    chk("rst_rbusy", 64'(m_rbusy), 64'd0);
    chk("rst_wbusy", 64'(m_wbusy), 64'd0);
    chk("rst_rdata", 64'(m_rdata), 64'd0);
    chk("rst_bus_err", 64'(bus_err), 64'd0);
    chk("rst_err_addr", 64'(err_addr), 64'd0);
    tick();
    reset = 1'b0;
    $display("txn reset done");

    // RAM read, zero wait states
    m_addr = 32'h0000_0100; m_rstrb = 1'b1; s_rdata[0 +: 32] = 32'hDEAD_BEEF;
    #1;
    chk("ram_rstrb", 64'(s_rstrb), 64'h01);
    tick();
    m_rstrb = 1'b0;
    #1;
    chk("ram_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
    chk("ram_rbusy", 64'(m_rbusy), 64'd0);
    tick();
    s_rdata[0 +: 32] = 32'h0;
    #1;
    chk("ram_hold", 64'(m_rdata), 64'hDEAD_BEEF);
    $display("txn ram_read addr=00000100");

    // Peripheral read with three wait states on slave 3
    m_addr = 32'h0042_0004; m_rstrb = 1'b1; s_busy[3] = 1'b1; s_rdata[3*32 +: 32] = 32'h1234_5678;
    #1;
    chk("per_rstrb", 64'(s_rstrb), 64'h08);
    tick();
    m_rstrb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("per_rbusy", 64'(m_rbusy), 64'd1);
      tick();
    end
    s_busy[3] = 1'b0;
    #1;
    chk("per_rbusy_end", 64'(m_rbusy), 64'd0);
    chk("per_rdata", 64'(m_rdata), 64'h1234_5678);
    tick();
    chk("per_no_err", 64'(bus_err), 64'd0);
    $display("txn periph_read addr=00420004");

    // Timeout on slave 1 stuck busy
    m_addr = 32'h0040_0000; m_rstrb = 1'b1; s_busy[1] = 1'b1;
    tick();
    m_rstrb = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("tout_rbusy", 64'(m_rbusy), 64'd1);
      tick();
    end
    #1;
    chk("tout_err_rbusy", 64'(m_rbusy), 64'd0);
    chk("tout_err_rdata", 64'(m_rdata), 64'h6666_6666);
    tick();
    s_busy[1] = 1'b0;
    chk("tout_bus_err", 64'(bus_err), 64'd1);
    chk("tout_code", 64'(err_code), 64'd2);
    chk("tout_addr", 64'(err_addr), 64'h0040_0000);
    chk("tout_rdata_hold", 64'(m_rdata), 64'h6666_6666);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tout_clr", 64'(bus_err), 64'd0);
    chk("tout_clr_code", 64'(err_code), 64'd0);
    $display("txn timeout addr=00400000");

    // Unmapped write inside the peripheral window
    m_addr = 32'h004A_0000; m_wmask = 4'hF; m_wdata = 32'hA5A5_A5A5;
    #1;
    chk("unm_wmask", 64'(s_wmask), 64'd0);
    chk("unm_cs", 64'(s_cs), 64'd0);
    chk("unm_wbusy", 64'(m_wbusy), 64'd0);
    tick();
    m_wmask = 4'h0;
    chk("unm_bus_err", 64'(bus_err), 64'd1);
    chk("unm_code", 64'(err_code), 64'd1);
    chk("unm_addr", 64'(err_addr), 64'h004A_0000);
    $display("txn unmapped_write addr=004A0000");

    // Read and write together: read wins, first error stays latched
    m_addr = 32'h0000_0200; m_rstrb = 1'b1; m_wmask = 4'h3; s_rdata[0 +: 32] = 32'hAAAA_5555;
    #1;
    chk("both_wmask", 64'(s_wmask), 64'd0);
    chk("both_rstrb", 64'(s_rstrb), 64'h01);
    tick();
    m_rstrb = 1'b0; m_wmask = 4'h0;
    #1;
    chk("both_rdata", 64'(m_rdata), 64'hAAAA_5555);
    chk("sticky_code", 64'(err_code), 64'd1);
    chk("sticky_addr", 64'(err_addr), 64'h004A_0000);
    tick();
    $display("txn read_write_collision addr=00000200");

    // Clear coinciding with a new error latches the new error
    err_clr = 1'b1; m_addr = 32'h004B_0000; m_wmask = 4'h1;
    tick();
    err_clr = 1'b0; m_wmask = 4'h0;
    chk("clr_new_err", 64'(bus_err), 64'd1);
    chk("clr_new_addr", 64'(err_addr), 64'h004B_0000);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_bus_err", 64'(bus_err), 64'd0);
    chk("clr_addr", 64'(err_addr), 64'd0);
    $display("txn error_clear");

    // Write stall on slave 4, mask held one extra cycle
    m_addr = 32'h0043_0010; m_wmask = 4'hF; m_wdata = 32'h0BAD_F00D; s_busy[4] = 1'b1;
    #1;
    chk("wr_issue_wmask", 64'(s_wmask), 64'h00F_0000);
    chk("wr_issue_wbusy", 64'(m_wbusy), 64'd0);
    tick();
    chk("wr_stall1", 64'(m_wbusy), 64'd1);
    chk("wr_no_fwd", 64'(s_wmask), 64'd0);
    tick();
    m_wmask = 4'h0;
    chk("wr_stall2", 64'(m_wbusy), 64'd1);
    tick();
    s_busy[4] = 1'b0;
    #1;
    chk("wr_done", 64'(m_wbusy), 64'd0);
    tick();
    chk("wr_proto_code", 64'(err_code), 64'd3);
    chk("wr_proto_addr", 64'(err_addr), 64'h0043_0010);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    $display("txn write_stall addr=00430010");

    // Asynchronous reset in the middle of a stalled read
    m_addr = 32'h0041_0000; m_rstrb = 1'b1; s_busy[2] = 1'b1; s_rdata[2*32 +: 32] = 32'h0000_0055;
    tick();
    m_rstrb = 1'b0;
    #1;
    chk("mid_rbusy", 64'(m_rbusy), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_rbusy", 64'(m_rbusy), 64'd0);
    chk("mid_rst_rdata", 64'(m_rdata), 64'd0);
    tick();
    reset = 1'b0; s_busy[2] = 1'b0;
    m_addr = 32'h0000_0000; m_rstrb = 1'b1; s_rdata[0 +: 32] = 32'hCAFE_F00D;
    #1;
    chk("post_rst_rstrb", 64'(s_rstrb), 64'h01);
    tick();
    m_rstrb = 1'b0;
    #1;
    chk("post_rst_rdata", 64'(m_rdata), 64'hCAFE_F00D);
    chk("post_rst_rbusy", 64'(m_rbusy), 64'd0);
    tick();
    $display("txn reset_mid_read addr=00410000");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/soc_bus_fabric.md
Name: soc_bus_fabric

Overview:
- Parametrised address decoder, read-data mux and wait-state controller between the FemtoRV32 memory port and N slaves (RAM plus memory-mapped peripherals).
- Adds features the flat decoder lacks:
  - read mux keyed on the registered select of the issuing cycle;
  - per-slave busy propagation;
  - bus timeout with error response;
  - unmapped-window detection;
  - sticky error status.
- Sits directly under the SoC top, between the CPU and every slave.

Parameters:
- N_SLAVES, 7, number of slave ports; slave 0 is default (RAM), slaves 1..N_SLAVES-1 are peripherals.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte mask width is DATA_W/8.
- TAG_HI, 31, MSB of the decode tag field.
- TAG_LO, 16, LSB of the decode tag field.
- PERIPH_BASE, 16'h0040, tag of slave 1; slave i decodes at PERIPH_BASE+i-1.
- PERIPH_SPAN, 16, tags reserved for peripherals from PERIPH_BASE; reserved tags with no slave are unmapped.
- TIMEOUT, 255, maximum busy cycles before error termination (1..65535).
- ERR_DATA, 32'h66666666, read data returned on error.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m_addr  in  ADDR_W  CPU address
- m_wdata  in  DATA_W  CPU write data
- m_wmask  in  DATA_W/8  CPU byte write mask; nonzero = write
- m_rstrb  in  1  CPU read strobe
- m_rdata  out  DATA_W  read data to CPU
- m_rbusy  out  1  read wait
- m_wbusy  out  1  write wait
- s_addr  out  ADDR_W  address broadcast to slaves
- s_wdata  out  DATA_W  write data broadcast to slaves
- s_cs  out  N_SLAVES  one-hot combinational chip select
- s_rstrb  out  N_SLAVES  per-slave read strobe
- s_wmask  out  N_SLAVES*DATA_W/8  per-slave byte mask; slave i owns bits [i*DATA_W/8 +: DATA_W/8]
- s_rdata  in  N_SLAVES*DATA_W  flattened slave read data
- s_busy  in  N_SLAVES  per-slave busy
- err_clr  in  1  clears the error status
- bus_err  out  1  sticky error flag
- err_addr  out  ADDR_W  address of the first error since last clear
- err_code  out  2  error code: 01 unmapped, 10 timeout, 11 request while busy

Behaviour:
- Decode, combinational, all states:
  - tag = m_addr[TAG_HI:TAG_LO].
  - tag in [PERIPH_BASE, PERIPH_BASE+N_SLAVES-2] selects slave tag-PERIPH_BASE+1.
  - tag in the rest of the reserved window [PERIPH_BASE, PERIPH_BASE+PERIPH_SPAN-1] is unmapped: s_cs=0.
  - any other tag selects slave 0.
- Forwarding:
  - s_rstrb = s_cs & m_rstrb, and s_wmask gated by s_cs, only in IDLE; all strobes and masks are 0 in other states.
  - s_addr and s_wdata pass through unconditionally.
- FSM states: IDLE, RD, WR, ERR.
  - IDLE, m_rstrb: register sel_q and unmapped_q, go to RD.
  - IDLE, |m_wmask, mapped: go to WR if s_busy[sel] is high, else stay in IDLE.
  - IDLE, |m_wmask, unmapped: write dropped, error 01 logged, stay in IDLE.
  - Read and write together in IDLE: read wins; write dropped; error 11 logged.
  - RD:
    - m_rdata = s_rdata[sel_q], m_rbusy = s_busy[sel_q].
    - When busy is low, the read completes that cycle and the FSM goes to IDLE; minimum read latency is 1 cycle after the strobe.
    - unmapped_q: m_rdata = ERR_DATA, m_rbusy = 0, error 01 logged, go to IDLE.
  - WR: m_wbusy = s_busy[sel_q]; go to IDLE when it is low.
  - Timeout: a 16-bit counter clears on entry to RD/WR and increments each cycle busy is high. When it reaches TIMEOUT, go to ERR.
  - ERR (1 cycle):
    - m_rbusy = m_wbusy = 0; m_rdata = ERR_DATA when the aborted access was a read.
    - error 10 logged; go to IDLE.
  - m_rstrb or m_wmask seen in RD/WR/ERR: not forwarded; error 11 logged.
- Outside RD and ERR-after-read, m_rdata holds its last value (register-backed).
- Error log:
  - The first error sets bus_err and latches err_addr and err_code; later errors do not overwrite until cleared.
  - err_clr clears bus_err, err_addr and err_code next cycle.
  - err_clr in the same cycle as a new error: the new error is latched.
- Reset, asynchronous, at any time including mid-transaction:
  - FSM to IDLE; counter, sel_q, unmapped_q, bus_err, err_addr, err_code, m_rdata cleared to 0.
  - m_rbusy = m_wbusy = 0; all strobes 0.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE=2'd0, RD=2'd1, WR=2'd2, ERR=2'd3;
  - error codes ERR_NONE/UNMAP/TOUT/PROTO;
  - the default PERIPH_BASE and the tag-field constants.
- One sub-module, bus_addr_decode: purely combinational tag to one-hot select plus unmapped flag, parametrised by N_SLAVES, PERIPH_BASE and PERIPH_SPAN. The FSM, mux and error log stay in the top module.

Test Plan:
- RAM read: m_addr=0x00000100, m_rstrb pulse, slave0 rdata=0xDEADBEEF, busy=0 -> s_rstrb=0000001; next cycle m_rdata=0xDEADBEEF, m_rbusy=0.
- Peripheral wait states: read 0x00420004, slave 3 busy for 3 cycles with rdata=0x12345678 -> m_rbusy=1 for 3 cycles, then m_rdata=0x12345678; bus_err stays 0.
- Timeout: TIMEOUT=8, read 0x00400000, slave 1 busy forever -> after 8 busy cycles m_rbusy drops, m_rdata=0x66666666, bus_err=1, err_code=10, err_addr=0x00400000.
- Unmapped: write mask 4'hF to 0x004A0000 -> all s_wmask=0, no stall, err_code=01; then err_clr -> bus_err=0 next cycle.
- Write stall then completion: write to 0x00430010, slave 4 busy 2 cycles -> m_wbusy=1 for 2 cycles, s_wmask forwarded only on the issue cycle.
- Reset mid-read: assert reset while in RD with slave busy -> FSM IDLE, m_rbusy=0 immediately; after release a read of 0x00000000 completes normally.
